// File: rtl/decode_queue_pkg.sv
// Shared opcode constants and control-bundle types for the fetch-side decode queue.
package decode_queue_pkg;

    localparam logic [10:0] HLT_OP   = 11'b11010100010;
    localparam logic [7:0]  CBZ_OP   = 8'b10110100;
    localparam logic [7:0]  BCOND_OP = 8'b01010100;
    localparam logic [5:0]  B_OP     = 6'b000101;
    localparam logic [10:0] LDUR_OP  = 11'b11111000010;
    localparam logic [10:0] STUR_OP  = 11'b11111000000;
    localparam logic [8:0]  MOVZ_OP  = 9'b110100101;
    localparam logic [8:0]  SUB_OP   = 9'b110100010;
    localparam logic [8:0]  ADD_OP   = 9'b100100010;
    localparam logic [10:0] CMP_OP   = 11'b11101011000;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_PASS = 2'b01,
        ALU_INSN = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic    reg2loc;
        logic    uncondBranch;
        logic    flagBranch;
        logic    zeroBranch;
        logic    memRead;
        logic    memToReg;
        logic    memWrite;
        logic    aluSrc;
        logic    regWrite;
        logic    useSp;
        logic    flagWrite;
        alu_op_t aluOp;
        logic    halt;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_queue_comb.sv
// Priority decoder: instruction word to control bundle, first match wins.
module decode_comb
    import decode_queue_pkg::*;
(
    input  logic [31:0] insn,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        if (insn[31:21] == HLT_OP) begin
            ctrl.halt = 1'b1;
        end else if (insn[31:24] == CBZ_OP) begin
            ctrl.reg2loc    = 1'b1;
            ctrl.zeroBranch = 1'b1;
            ctrl.aluOp      = ALU_PASS;
        end else if (insn[31:24] == BCOND_OP && !insn[4]) begin
            ctrl.flagBranch = 1'b1;
        end else if (insn[31:26] == B_OP) begin
            ctrl.uncondBranch = 1'b1;
        end else if (insn[31:21] == LDUR_OP) begin
            ctrl.aluSrc   = 1'b1;
            ctrl.memRead  = 1'b1;
            ctrl.memToReg = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.aluOp    = ALU_ADD;
        end else if (insn[31:21] == STUR_OP) begin
            ctrl.reg2loc  = 1'b1;
            ctrl.aluSrc   = 1'b1;
            ctrl.memWrite = 1'b1;
            ctrl.aluOp    = ALU_ADD;
        end else if (insn[31:23] == MOVZ_OP) begin
            ctrl.regWrite = 1'b1;
            ctrl.aluSrc   = 1'b1;
            ctrl.aluOp    = ALU_INSN;
        end else if (insn[31:23] == SUB_OP || insn[31:23] == ADD_OP) begin
            ctrl.regWrite = 1'b1;
            ctrl.aluSrc   = 1'b1;
            ctrl.useSp    = 1'b1;
            ctrl.aluOp    = ALU_INSN;
        end else if (insn[31:21] == CMP_OP && insn[4:0] == 5'b11111) begin
            ctrl.flagWrite = 1'b1;
            ctrl.aluOp     = ALU_PASS;
        end else begin
            // Unknown opcodes still travel down the queue so the fault is raised in order.
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes fetched instructions into a DEPTH-entry FIFO,
// with halt sequencing and branch-redirect flush.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int PC_W  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    input  logic            resume,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_reg2loc,
    output logic            out_uncond_branch,
    output logic            out_flag_branch,
    output logic            out_zero_branch,
    output logic            out_mem_read,
    output logic            out_mem_to_reg,
    output logic            out_mem_write,
    output logic            out_alu_src,
    output logic            out_reg_write,
    output logic            out_use_sp,
    output logic            out_flag_write,
    output logic [1:0]      out_alu_op,
    output logic [31:0]     out_insn,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal,
    output logic            out_halt,
    output logic            halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    ctrl_t           ctrlMem [DEPTH];
    logic [31:0]     insnMem [DEPTH];
    logic [PC_W-1:0] pcMem   [DEPTH];

    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count;
    logic             haltPending;
    logic             inReady, outValid, push, pop;
    ctrl_t            decCtrl, head;

    decode_comb uDecode (
        .insn (in_insn),
        .ctrl (decCtrl)
    );

    // Ready depends only on registered state, never on out_ready or in_valid.
    assign inReady  = (count != CNT_FULL) && !haltPending && !halted;
    assign outValid = (count != '0);
    assign push     = in_valid && inReady && !flush;
    assign pop      = outValid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            ctrlMem[wrPtr] <= decCtrl;
            insnMem[wrPtr] <= in_insn;
            pcMem[wrPtr]   <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            haltPending <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PTR_ONE;
                if (pop)  rdPtr <= rdPtr + PTR_ONE;
                if (push && !pop)      count <= count + CNT_ONE;
                else if (!push && pop) count <= count - CNT_ONE;
            end

            if (flush || (resume && halted)) haltPending <= 1'b0;
            else if (push && decCtrl.halt)   haltPending <= 1'b1;

            // A dequeue in a flush cycle still completes, so a HLT leaving then halts.
            if (pop && head.halt)       halted <= 1'b1;
            else if (resume && halted)  halted <= 1'b0;
        end
    end

    // Empty queue presents an all-zero payload rather than stale storage.
    assign head     = outValid ? ctrlMem[rdPtr] : ctrl_t'('0);
    assign out_insn = outValid ? insnMem[rdPtr] : '0;
    assign out_pc   = outValid ? pcMem[rdPtr]   : '0;

    assign in_ready          = inReady;
    assign out_valid         = outValid;
    assign out_reg2loc       = head.reg2loc;
    assign out_uncond_branch = head.uncondBranch;
    assign out_flag_branch   = head.flagBranch;
    assign out_zero_branch   = head.zeroBranch;
    assign out_mem_read      = head.memRead;
    assign out_mem_to_reg    = head.memToReg;
    assign out_mem_write     = head.memWrite;
    assign out_alu_src       = head.aluSrc;
    assign out_reg_write     = head.regWrite;
    assign out_use_sp        = head.useSp;
    assign out_flag_write    = head.flagWrite;
    assign out_alu_op        = head.aluOp;
    assign out_illegal       = head.illegal;
    assign out_halt          = head.halt;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: queue-based reference model checked every cycle,
// plus literal expectations at key points.
module tb_decode_queue;

    localparam int PC_W  = 64;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0, in_ready;
    logic [31:0]     in_insn = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            flush = 1'b0, resume = 1'b0;
    logic            out_valid, out_ready = 1'b0;
    logic            out_reg2loc, out_uncond_branch, out_flag_branch, out_zero_branch;
    logic            out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src;
    logic            out_reg_write, out_use_sp, out_flag_write;
    logic [1:0]      out_alu_op;
    logic [31:0]     out_insn;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal, out_halt, halted;

    always #5 clk = ~clk;

    decode_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .flush(flush), .resume(resume),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg2loc(out_reg2loc), .out_uncond_branch(out_uncond_branch),
        .out_flag_branch(out_flag_branch), .out_zero_branch(out_zero_branch),
        .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_write(out_mem_write), .out_alu_src(out_alu_src),
        .out_reg_write(out_reg_write), .out_use_sp(out_use_sp),
        .out_flag_write(out_flag_write), .out_alu_op(out_alu_op),
        .out_insn(out_insn), .out_pc(out_pc),
        .out_illegal(out_illegal), .out_halt(out_halt), .halted(halted)
    );

    // {reg2loc, uncond, flag, zero, memRead, memToReg, memWrite, aluSrc, regWrite, useSp, flagWrite, aluOp[1:0], halt, illegal}
    logic [14:0] dutCtrl;
    assign dutCtrl = {out_reg2loc, out_uncond_branch, out_flag_branch, out_zero_branch,
                      out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src,
                      out_reg_write, out_use_sp, out_flag_write, out_alu_op,
                      out_halt, out_illegal};

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode table in priority order: mask, match, resulting control vector.
    localparam logic [31:0] MASKS [10] = '{32'hFFE00000, 32'hFF000000, 32'hFF000010, 32'hFC000000,
                                           32'hFFE00000, 32'hFFE00000, 32'hFF800000, 32'hFF800000,
                                           32'hFF800000, 32'hFFE0001F};
    localparam logic [31:0] MATCH [10] = '{32'hD4400000, 32'hB4000000, 32'h54000000, 32'h14000000,
                                           32'hF8400000, 32'hF8000000, 32'hD2800000, 32'hD1000000,
                                           32'h91000000, 32'hEB00001F};
    localparam logic [14:0] BITS  [10] = '{15'b0_0_0_0_0_0_0_0_0_0_0_00_1_0,   // HLT
                                           15'b1_0_0_1_0_0_0_0_0_0_0_01_0_0,   // CBZ
                                           15'b0_0_1_0_0_0_0_0_0_0_0_00_0_0,   // B.cond
                                           15'b0_1_0_0_0_0_0_0_0_0_0_00_0_0,   // B
                                           15'b0_0_0_0_1_1_0_1_1_0_0_00_0_0,   // LDUR
                                           15'b1_0_0_0_0_0_1_1_0_0_0_00_0_0,   // STUR
                                           15'b0_0_0_0_0_0_0_1_1_0_0_10_0_0,   // MOVZ
                                           15'b0_0_0_0_0_0_0_1_1_1_0_10_0_0,   // SUB imm
                                           15'b0_0_0_0_0_0_0_1_1_1_0_10_0_0,   // ADD imm
                                           15'b0_0_0_0_0_0_0_0_0_0_1_01_0_0};  // CMP

    function automatic logic [14:0] modelDecode(input logic [31:0] w);
        logic [14:0] r;
        bit found;
        r = 15'd1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (!found && ((w & MASKS[i]) == MATCH[i])) begin
                r = BITS[i];
                found = 1;
            end
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0]     insn;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t        q[$];
    ent_t        newEnt;
    bit          mHaltPend = 0, mHalted = 0;
    bit          mRdy, doPop, doPush, popHalt;
    logic [14:0] hd, pd, expCtrl;

    // Reference model advances on the same edge as the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mHaltPend = 0;
            mHalted = 0;
        end else begin
            mRdy = (q.size() != DEPTH) && !mHaltPend && !mHalted;
            doPop = (q.size() != 0) && out_ready;
            popHalt = 0;
            if (doPop) begin
                hd = modelDecode(q[0].insn);
                popHalt = hd[1];
            end
            doPush = in_valid && mRdy && !flush;
            if (flush) begin
                q.delete();
                mHaltPend = 0;
            end else begin
                if (doPop) void'(q.pop_front());
                if (doPush) begin
                    newEnt.insn = in_insn;
                    newEnt.pc = in_pc;
                    q.push_back(newEnt);
                    pd = modelDecode(in_insn);
                    if (pd[1]) mHaltPend = 1;
                end
            end
            if (popHalt) mHalted = 1;
            else if (resume && mHalted) begin
                mHalted = 0;
                mHaltPend = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, (q.size() != DEPTH) && !mHaltPend && !mHalted);
        chk("out_valid", out_valid, q.size() != 0);
        chk("halted", halted, mHalted);
        if (q.size() != 0) begin
            expCtrl = modelDecode(q[0].insn);
            chk("head_insn", out_insn, q[0].insn);
            chk("head_pc", out_pc, q[0].pc);
            chk("head_ctrl", dutCtrl, expCtrl);
        end else if (rst) begin
            chk("rst_ctrl", dutCtrl, 15'd0);
            chk("rst_insn", out_insn, 32'd0);
            chk("rst_pc", out_pc, 64'd0);
        end
    end

    task automatic step(input logic v, input logic [31:0] w, input logic [63:0] p,
                        input logic ordy, input logic fl, input logic res);
        in_valid = v; in_insn = w; in_pc = p; out_ready = ordy; flush = fl; resume = res;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; flush = 0; resume = 0;
    endtask

    localparam logic [31:0] I_ADD  = 32'h91000420;
    localparam logic [31:0] I_CBZ  = 32'hB4000040;
    localparam logic [31:0] I_LDUR = 32'hF8400020;
    localparam logic [31:0] I_HLT  = 32'hD4400000;
    localparam logic [31:0] I_CMP  = 32'hEB01001F;
    localparam logic [31:0] I_B    = 32'h14000010;
    localparam logic [31:0] I_STUR = 32'hF8000020;
    localparam logic [31:0] I_MOVZ = 32'hD2800040;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_ctrl", dutCtrl, 0);
        chk("reset_pc", out_pc, 0);
        rst = 0;

        // Streaming at one per cycle
        step(1, I_ADD, 64'h1000, 1, 0, 0);
        chk("add_reg_write", out_reg_write, 1);
        chk("add_alu_src", out_alu_src, 1);
        chk("add_use_sp", out_use_sp, 1);
        chk("add_alu_op", out_alu_op, 2'b10);
        chk("add_pc", out_pc, 64'h1000);
        step(1, I_CBZ, 64'h1004, 1, 0, 0);
        chk("cbz_reg2loc", out_reg2loc, 1);
        chk("cbz_zero_branch", out_zero_branch, 1);
        chk("cbz_alu_op", out_alu_op, 2'b01);
        chk("cbz_insn", out_insn, I_CBZ);
        step(1, I_LDUR, 64'h1008, 1, 0, 0);
        chk("ldur_mem_read", out_mem_read, 1);
        step(0, 0, 0, 1, 0, 0);
        chk("stream_drained", out_valid, 0);

        // Back-pressure until full, then drain
        step(1, I_B, 64'h2000, 0, 0, 0);
        step(1, I_STUR, 64'h2004, 0, 0, 0);
        chk("full_in_ready", in_ready, 0);
        step(1, I_MOVZ, 64'h2008, 0, 0, 0);
        chk("held_head_pc", out_pc, 64'h2000);
        step(1, I_MOVZ, 64'h2008, 1, 0, 0);
        chk("drain1_pc", out_pc, 64'h2004);
        step(1, I_MOVZ, 64'h2008, 1, 0, 0);
        chk("drain2_pc", out_pc, 64'h2008);
        step(0, 0, 0, 1, 0, 0);
        chk("drain_empty", out_valid, 0);

        // Halt sequencing
        step(1, I_HLT, 64'h3000, 0, 0, 0);
        chk("hlt_in_ready", in_ready, 0);
        chk("hlt_out_halt", out_halt, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("early_resume_ignored", in_ready, 0);
        step(1, I_ADD, 64'h3004, 1, 0, 0);
        chk("halted_set", halted, 1);
        chk("halted_no_accept", out_valid, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("resume_halted", halted, 0);
        chk("resume_ready", in_ready, 1);

        // Flush with a simultaneous offer
        step(1, I_LDUR, 64'h4000, 0, 0, 0);
        step(1, I_ADD, 64'h4004, 0, 0, 0);
        step(1, I_MOVZ, 64'h4008, 0, 1, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_offer_dropped", out_valid, 0);

        // Flush coinciding with the HLT dequeue still halts
        step(1, I_HLT, 64'h4100, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("flush_hlt_halted", halted, 1);
        chk("flush_hlt_ready", in_ready, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("flush_hlt_resume", halted, 0);

        // Illegal and edge opcodes
        step(1, 32'h00000000, 64'h5000, 1, 0, 0);
        chk("zero_illegal", out_illegal, 1);
        chk("zero_ctrl", dutCtrl[14:2], 0);
        step(1, I_CMP, 64'h5004, 1, 0, 0);
        chk("cmp_flag_write", out_flag_write, 1);
        chk("cmp_alu_op", out_alu_op, 2'b01);
        step(1, 32'h54000001, 64'h5008, 1, 0, 0);
        chk("bcond_flag_branch", out_flag_branch, 1);
        step(1, 32'h54000010, 64'h500C, 1, 0, 0);
        chk("bcond_bit4_illegal", out_illegal, 1);
        step(0, 0, 0, 1, 0, 0);

        // Asynchronous reset with a full queue
        step(1, I_LDUR, 64'h6000, 0, 0, 0);
        step(1, I_ADD, 64'h6004, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_ctrl", dutCtrl, 0);
        chk("async_rst_pc", out_pc, 0);
        chk("async_rst_insn", out_insn, 0);
        @(negedge clk);
        rst = 0;
        step(0, 0, 0, 0, 0, 0);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_empty", out_valid, 0);
        step(1, I_MOVZ, 64'h6100, 1, 0, 0);
        chk("post_rst_push_pc", out_pc, 64'h6100);
        step(0, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
